// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-master device-port arbiter.
package dev_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned CNT_W_DEF     = 3;

endpackage

// File: rtl/dev_bus_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on a tie, the master that did not own the bus last wins.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic pick_valid,
   output logic pick
);

   always_comb begin
      pick_valid = req0 | req1;
      pick       = (req0 & req1) ? ~last : req1;
   end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing the bridge's PrAddr/PrWD/PrWE/PrRD port between
// the CPU memory stage (M0) and a DMA/debug master (M1), with bounded bursts.
module dev_bus_arbiter
   import dev_bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        we0,
   input  logic [29:0] addr0,
   input  logic [31:0] wdata0,
   output logic        gnt0,
   output logic [31:0] rdata0,
   output logic        rvalid0,
   input  logic        req1,
   input  logic        we1,
   input  logic [29:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt1,
   output logic [31:0] rdata1,
   output logic        rvalid1,
   output logic [29:0] PrAddr,
   output logic [31:0] PrWD,
   output logic        PrWE,
   input  logic [31:0] PrRD
);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata0_q, rdata1_q;
   logic              rvalid0_q, rvalid1_q;

   logic              beat0, beat1, burst_end;
   logic              pick_valid, pick;

   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last       (last_q),
      .pick_valid (pick_valid),
      .pick       (pick)
   );

   assign beat0     = (state_q == OWN0) & req0;
   assign beat1     = (state_q == OWN1) & req1;
   assign burst_end = (cnt_q == CNT_W'(MAX_BURST - 1));

   always_comb begin
      gnt0   = beat0;
      gnt1   = beat1;
      PrAddr = '0;
      PrWD   = '0;
      PrWE   = 1'b0;
      if (beat0) begin
         PrAddr = addr0;
         PrWD   = wdata0;
         PrWE   = we0;
      end else if (beat1) begin
         PrAddr = addr1;
         PrWD   = wdata1;
         PrWE   = we1;
      end
   end

   // Burst limit only forces a release when the other master is waiting; otherwise cnt wraps.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick_valid) state_d = pick ? OWN1 : OWN0;
         end
         OWN0: begin
            if (!req0) begin
               state_d = IDLE;
               last_d  = 1'b0;
               cnt_d   = '0;
            end else if (burst_end) begin
               cnt_d = '0;
               if (req1) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         OWN1: begin
            if (!req1) begin
               state_d = IDLE;
               last_d  = 1'b1;
               cnt_d   = '0;
            end else if (burst_end) begin
               cnt_d = '0;
               if (req0) begin
                  state_d = IDLE;
                  last_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         rvalid0_q <= beat0 & ~we0;
         rvalid1_q <= beat1 & ~we1;
         if (beat0 & ~we0) rdata0_q <= PrRD;
         if (beat1 & ~we1) rdata1_q <= PrRD;
      end
   end

   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a tenure-level reference model.
module tb_dev_bus_arbiter;

   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, we0, req1, we1;
   logic [29:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata0, rdata1;
   logic [29:0] PrAddr;
   logic [31:0] PrWD;
   logic        PrWE;
   logic [31:0] PrRD;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dev_bus_arbiter #(.MAX_BURST(MB), .CNT_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .req0    (req0),
      .we0     (we0),
      .addr0   (addr0),
      .wdata0  (wdata0),
      .gnt0    (gnt0),
      .rdata0  (rdata0),
      .rvalid0 (rvalid0),
      .req1    (req1),
      .we1     (we1),
      .addr1   (addr1),
      .wdata1  (wdata1),
      .gnt1    (gnt1),
      .rdata1  (rdata1),
      .rvalid1 (rvalid1),
      .PrAddr  (PrAddr),
      .PrWD    (PrWD),
      .PrWE    (PrWE),
      .PrRD    (PrRD)
   );

   // Reference model: who holds the bus, beats in this tenure, last owner, read returns.
   int          m_owner;
   int          m_beats;
   int          m_last;
   logic        m_rv [2];
   logic [31:0] m_rd [2];

   typedef struct {
      logic        req0, we0;
      logic [29:0] addr0;
      logic        req1, we1;
      logic [29:0] addr1;
      logic [31:0] wdata1;
      logic [31:0] prrd;
      logic        e_gnt0, e_gnt1, e_we;
      logic [29:0] e_addr;
      logic [31:0] e_wd;
      logic        e_rv0;
      logic [31:0] e_rd0;
   } vec_t;

   vec_t vt [12];

   function automatic vec_t mk(logic r0, logic w0, logic [29:0] a0,
                               logic r1, logic w1, logic [29:0] a1, logic [31:0] d1,
                               logic [31:0] rd, logic g0, logic g1, logic ew,
                               logic [29:0] ea, logic [31:0] ed, logic v0, logic [31:0] erd0);
      vec_t v;
      v.req0 = r0;  v.we0 = w0;  v.addr0 = a0;
      v.req1 = r1;  v.we1 = w1;  v.addr1 = a1;  v.wdata1 = d1;
      v.prrd = rd;
      v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_we = ew;
      v.e_addr = ea; v.e_wd = ed;  v.e_rv0 = v0; v.e_rd0 = erd0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_beats = 0;
      m_last  = 1;
      for (int n = 0; n < 2; n++) begin
         m_rv[n] = 1'b0;
         m_rd[n] = '0;
      end
   endtask

   task automatic model_edge();
      bit rq [2];
      bit wr [2];
      int o;
      rq[0] = req0; rq[1] = req1; wr[0] = we0; wr[1] = we1;
      for (int n = 0; n < 2; n++) begin
         m_rv[n] = (m_owner == n) && rq[n] && !wr[n];
         if (m_rv[n]) m_rd[n] = PrRD;
      end
      o = m_owner;
      if (o < 0) begin
         if (rq[0] && rq[1]) m_owner = 1 - m_last;
         else if (rq[0])     m_owner = 0;
         else if (rq[1])     m_owner = 1;
      end else if (!rq[o]) begin
         m_last  = o;
         m_owner = -1;
         m_beats = 0;
      end else begin
         m_beats++;
         if (m_beats == MB) begin
            m_beats = 0;
            if (rq[1-o]) begin
               m_last  = o;
               m_owner = -1;
            end
         end
      end
   endtask

   task automatic check_model();
      bit          g0, g1, ew;
      logic [29:0] ea;
      logic [31:0] ed;
      g0 = (m_owner == 0) && req0;
      g1 = (m_owner == 1) && req1;
      ea = '0; ed = '0; ew = 1'b0;
      if (g0) begin
         ea = addr0; ed = wdata0; ew = we0;
      end else if (g1) begin
         ea = addr1; ed = wdata1; ew = we1;
      end
      chk("m_gnt0",    32'(gnt0),    32'(g0));
      chk("m_gnt1",    32'(gnt1),    32'(g1));
      chk("m_PrAddr",  32'(PrAddr),  32'(ea));
      chk("m_PrWD",    PrWD,         ed);
      chk("m_PrWE",    32'(PrWE),    32'(ew));
      chk("m_rvalid0", 32'(rvalid0), 32'(m_rv[0]));
      chk("m_rvalid1", 32'(rvalid1), 32'(m_rv[1]));
      chk("m_rdata0",  rdata0,       m_rd[0]);
      chk("m_rdata1",  rdata1,       m_rd[1]);
      chk("rv_excl",   32'(rvalid0 & rvalid1), 32'd0);
      chk("gnt_excl",  32'(gnt0 & gnt1),       32'd0);
   endtask

   // Inputs are driven 1 time unit after posedge; outputs checked 1 unit later.
   task automatic tick();
      #1;
      check_model();
      @(posedge clk);
      if (reset) model_edge();
      #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_gnt0"},    32'(gnt0),    32'd0);
      chk({nm, "_gnt1"},    32'(gnt1),    32'd0);
      chk({nm, "_PrWE"},    32'(PrWE),    32'd0);
      chk({nm, "_PrAddr"},  32'(PrAddr),  32'd0);
      chk({nm, "_PrWD"},    PrWD,         32'd0);
      chk({nm, "_rvalid0"}, 32'(rvalid0), 32'd0);
      chk({nm, "_rvalid1"}, 32'(rvalid1), 32'd0);
   endtask

   initial begin
      bit eg0, eg1;
      vt[0]  = mk(1'b1, 1'b0, 30'h1F80, 1'b0, 1'b0, 30'h0, 32'h0, 32'hDEAD_BEEF,
                  1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0);
      vt[1]  = mk(1'b1, 1'b0, 30'h1F80, 1'b0, 1'b0, 30'h0, 32'h0, 32'hDEAD_BEEF,
                  1'b1, 1'b0, 1'b0, 30'h1F80, 32'h0, 1'b0, 32'h0);
      vt[2]  = mk(1'b0, 1'b0, 30'h1F80, 1'b0, 1'b0, 30'h0, 32'h0, 32'h1111_2222,
                  1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      vt[3]  = mk(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 32'h3333_4444,
                  1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      vt[4]  = mk(1'b0, 1'b0, 30'h0, 1'b1, 1'b1, 30'h1F84, 32'h9, 32'h5555_6666,
                  1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
      for (int i = 5; i <= 10; i++)
         vt[i] = mk(1'b0, 1'b0, 30'h0, 1'b1, 1'b1, 30'h1F84, 32'h9, 32'h7777_8888,
                    1'b0, 1'b1, 1'b1, 30'h1F84, 32'h9, 1'b0, 32'hDEAD_BEEF);
      vt[11] = mk(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 32'h0,
                  1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);

      reset = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      PrRD = '0;
      model_reset();
      #1;
      chk_all_zero("reset");
      chk("reset_rdata0", rdata0, 32'd0);
      chk("reset_rdata1", rdata1, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Directed table: M0 single read, then M1 six-beat write burst with cnt wrap.
      for (int i = 0; i < 12; i++) begin
         req0 = vt[i].req0; we0 = vt[i].we0; addr0 = vt[i].addr0; wdata0 = '0;
         req1 = vt[i].req1; we1 = vt[i].we1; addr1 = vt[i].addr1; wdata1 = vt[i].wdata1;
         PrRD = vt[i].prrd;
         #1;
         chk($sformatf("vec%0d_gnt0", i),    32'(gnt0),    32'(vt[i].e_gnt0));
         chk($sformatf("vec%0d_gnt1", i),    32'(gnt1),    32'(vt[i].e_gnt1));
         chk($sformatf("vec%0d_PrWE", i),    32'(PrWE),    32'(vt[i].e_we));
         chk($sformatf("vec%0d_PrAddr", i),  32'(PrAddr),  32'(vt[i].e_addr));
         chk($sformatf("vec%0d_PrWD", i),    PrWD,         vt[i].e_wd);
         chk($sformatf("vec%0d_rvalid0", i), 32'(rvalid0), 32'(vt[i].e_rv0));
         chk($sformatf("vec%0d_rdata0", i),  rdata0,       vt[i].e_rd0);
         tick();
      end

      // Continuous contention: 4 beats each with a one-cycle bubble between owners.
      req0 = 1'b1; we0 = 1'b0; addr0 = 30'h0000_0100;
      req1 = 1'b1; we1 = 1'b0; addr1 = 30'h0000_0200;
      for (int c = 0; c < 15; c++) begin
         PrRD = $urandom;
         eg0 = (c != 0) && (((c - 1) % 5) != 4) && ((((c - 1) / 5) % 2) == 0);
         eg1 = (c != 0) && (((c - 1) % 5) != 4) && ((((c - 1) / 5) % 2) == 1);
         #1;
         chk($sformatf("burst%0d_gnt0", c), 32'(gnt0), 32'(eg0));
         chk($sformatf("burst%0d_gnt1", c), 32'(gnt1), 32'(eg1));
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // M0 final read beat coincides with forced release; rvalid0 lands in IDLE.
      req0 = 1'b1; we0 = 1'b0; addr0 = 30'h0000_0040;
      tick();
      req1 = 1'b1; we1 = 1'b0; addr1 = 30'h0000_0080;
      for (int b = 0; b < 4; b++) begin
         PrRD = 32'hA000_0000 + 32'(b);
         #1;
         chk($sformatf("rel_beat%0d_gnt0", b), 32'(gnt0), 32'd1);
         tick();
      end
      req0 = 1'b0;
      PrRD = 32'hBBBB_0001;
      #1;
      chk("rel_idle_rvalid0", 32'(rvalid0), 32'd1);
      chk("rel_idle_rdata0",  rdata0,       32'hA000_0003);
      chk("rel_idle_gnt0",    32'(gnt0),    32'd0);
      chk("rel_idle_gnt1",    32'(gnt1),    32'd0);
      tick();

      // Reset asserted during an M1 read beat: the read is discarded.
      PrRD = 32'hCAFE_F00D;
      #1;
      chk("rst_pre_gnt1", 32'(gnt1), 32'd1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk_all_zero("rst_async");
      chk("rst_async_rdata0", rdata0, 32'd0);
      chk("rst_async_rdata1", rdata1, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_rvalid1", 32'(rvalid1), 32'd0);
      tick();
      reset = 1'b1;
      req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
      #1;
      chk("rst_tie_idle_gnt0", 32'(gnt0), 32'd0);
      tick();
      #1;
      chk("rst_tie_gnt0", 32'(gnt0), 32'd1);
      chk("rst_tie_gnt1", 32'(gnt1), 32'd0);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // Quiet bus: everything stays at zero.
      for (int c = 0; c < 10; c++) begin
         PrRD = $urandom;
         addr0 = 30'($urandom); addr1 = 30'($urandom);
         wdata0 = $urandom; wdata1 = $urandom;
         #1;
         chk_all_zero($sformatf("idle%0d", c));
         tick();
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         req0   = ($urandom_range(0, 3) != 0);
         req1   = ($urandom_range(0, 3) != 0);
         we0    = $urandom_range(0, 1) == 1;
         we1    = $urandom_range(0, 1) == 1;
         addr0  = 30'($urandom);
         addr1  = 30'($urandom);
         wdata0 = $urandom;
         wdata1 = $urandom;
         PrRD   = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
